filter_system: RTL and testbench

Parametrised image-filter pipeline with frame-level control: RGB FIFO → grayscale → grayscale FIFO → (sobel | bypass) → output FIFO. A frame controller admits exactly IMG_WIDTH×IMG_HEIGHT input pixels per frame, latches the filter mode at frame start, and pulses `frame_done` when the last output pixel has been read. It is the top-level DUT between the testbench RGB memory and the result memory.

---
 rtl/filter_system_pkg.sv | 18 +
 rtl/filter_system_fifo.sv | 53 +++++
 rtl/filter_system_frame_ctrl.sv | 101 ++++++++++
 rtl/filter_system_sobel.sv | 88 ++++++++
 rtl/filter_system.sv | 100 ++++++++++
 tb/tb_filter_system.sv | 183 ++++++++++++++++++
 6 files changed

// File: rtl/filter_system_pkg.sv
// Shared types and helpers for the filter_system image pipeline.
package filter_system_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_GRAY  = 1'b0;
    localparam logic MODE_SOBEL = 1'b1;

    function automatic int frame_pixels(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/filter_system_fifo.sv
// Show-ahead synchronous FIFO. wr_pending lowers the reported full level so
// an upstream register stage can check for room one cycle ahead of its write.
module filter_system_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [DW-1:0] din,
    input  logic          wr_pending,
    output logic          full,
    input  logic          rd_en,
    output logic [DW-1:0] dout,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][DW-1:0] mem;
    logic [AW-1:0]            wp, rp;
    logic [AW:0]              cnt;
    logic                     do_wr, do_rd;

    // Flags and handshake qualification
    always_comb begin
        empty = (cnt == '0);
        full  = (cnt + (AW+1)'(wr_pending)) >= (AW+1)'(DEPTH);
        do_wr = wr_en && (cnt != (AW+1)'(DEPTH));
        do_rd = rd_en && !empty;
        dout  = mem[rp];
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem <= '0;
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_wr) begin
                mem[wp] <= din;
                wp      <= wp + 1'b1;
            end
            if (do_rd) rp <= rp + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/filter_system_frame_ctrl.sv
// Frame controller: admits exactly W*H input pixels, counts output reads,
// latches the filter mode at frame start and pulses frame_done.
// Optional stall counters under FILTER_SYSTEM_STATS_EN.
module frame_ctrl
    import filter_system_pkg::*;
#(
    parameter int W = 720,
    parameter int H = 540
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        mode,
    input  logic        in_wr_en,
    input  logic        rgb_full,
    input  logic        out_rd_en,
    input  logic        out_empty,
    output logic        in_full,
    output logic        wr_accept,
    output logic        busy,
    output logic        frame_done,
    output logic        mode_q,
    output logic        frame_clr
`ifdef FILTER_SYSTEM_STATS_EN
   ,output logic [31:0] stall_in_cnt,
    output logic [31:0] stall_out_cnt
`endif
);
    localparam int N  = frame_pixels(W, H);
    localparam int CW = $clog2(N + 1);

    state_t        state, state_nxt;
    logic [CW-1:0] in_cnt, out_cnt;
    logic          rd_ok;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and frame-level gating
    always_comb begin
        state_nxt  = state;
        in_full    = 1'b1;
        busy       = 1'b0;
        frame_done = 1'b0;
        frame_clr  = 1'b0;
        case (state)
            IDLE: if (frame_start) begin
                frame_clr = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                busy    = 1'b1;
                in_full = rgb_full;
                if (in_wr_en && !rgb_full && in_cnt == CW'(N - 1)) state_nxt = DRAIN;
            end
            DRAIN: busy = 1'b1;
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        wr_accept = in_wr_en && !in_full;
        rd_ok     = out_rd_en && !out_empty && busy;
        if (rd_ok && out_cnt == CW'(N - 1)) state_nxt = DONE;
    end

    // Pixel counters and mode latch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            mode_q  <= MODE_GRAY;
        end else if (frame_clr) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            mode_q  <= mode;
        end else begin
            if (wr_accept) in_cnt  <= in_cnt + 1'b1;
            if (rd_ok)     out_cnt <= out_cnt + 1'b1;
        end
    end

`ifdef FILTER_SYSTEM_STATS_EN
    // Saturating stall counters, restarted with each accepted frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset || frame_clr) begin
            stall_in_cnt  <= '0;
            stall_out_cnt <= '0;
        end else begin
            if (state == RUN && in_wr_en && in_full && stall_in_cnt != '1)
                stall_in_cnt <= stall_in_cnt + 1'b1;
            if (busy && out_empty && out_rd_en && stall_out_cnt != '1)
                stall_out_cnt <= stall_out_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: rtl/filter_system_sobel.sv
// Streaming 3x3 Sobel: one output per input pixel, raster order. Output for
// pixel i is formed when pixel i+W+1 arrives; the trailing W+1 outputs are
// all border pixels and are flushed as zeros once the input is exhausted.
module filter_system_sobel
    import filter_system_pkg::*;
#(
    parameter int W  = 720,
    parameter int H  = 540,
    parameter int PW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clr,
    input  logic          empty,
    input  logic [PW-1:0] din,
    output logic          rd_en,
    input  logic          full,
    output logic          wr_en,
    output logic [PW-1:0] dout
);
    localparam int N    = frame_pixels(W, H);
    localparam int CW   = $clog2(N + 1);
    localparam int XW   = $clog2(W + 1);
    localparam int YW   = $clog2(H + 1);
    localparam int MAXV = (1 << PW) - 1;

    // sr[0] is the previous pixel, sr[2W+1] the oldest one kept
    logic [2*W+1:0][PW-1:0] sr;
    logic [CW-1:0]          in_idx, out_idx;
    logic [XW-1:0]          ox;
    logic [YW-1:0]          oy;
    logic                   flush, border;
    logic [PW+1:0]          l, r, t, b, dx, dy;
    logic [PW+2:0]          mag;

    function automatic logic [PW+1:0] wsum(input logic [PW-1:0] a, m, c);
        return (PW+2)'(a) + (PW+2)'({m, 1'b0}) + (PW+2)'(c);
    endfunction

    // Window taps, gradient magnitude and stream handshake
    always_comb begin
        l   = wsum(sr[2*W+1], sr[W+1], sr[1]);
        r   = wsum(sr[2*W-1], sr[W-1], din);
        t   = wsum(sr[2*W+1], sr[2*W], sr[2*W-1]);
        b   = wsum(sr[1], sr[0], din);
        dx  = (r > l) ? r - l : l - r;
        dy  = (b > t) ? b - t : t - b;
        mag = (PW+3)'(dx) + (PW+3)'(dy);
        flush  = (in_idx == CW'(N)) && (out_idx < CW'(N));
        border = flush || (ox == '0) || (ox == XW'(W - 1)) ||
                 (oy == '0) || (oy == YW'(H - 1));
        rd_en = !empty && (in_idx < CW'(N)) && ((in_idx < CW'(W + 1)) || !full);
        wr_en = (rd_en && (in_idx >= CW'(W + 1))) || (flush && !full);
        if (border)                  dout = '0;
        else if (mag > (PW+3)'(MAXV)) dout = PW'(MAXV);
        else                         dout = mag[PW-1:0];
    end

    // Line buffer shift and raster position of the next output
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sr      <= '0;
            in_idx  <= '0;
            out_idx <= '0;
            ox      <= '0;
            oy      <= '0;
        end else if (clr) begin
            in_idx  <= '0;
            out_idx <= '0;
            ox      <= '0;
            oy      <= '0;
        end else begin
            if (rd_en) begin
                sr     <= {sr[2*W:0], din};
                in_idx <= in_idx + 1'b1;
            end
            if (wr_en) begin
                out_idx <= out_idx + 1'b1;
                if (ox == XW'(W - 1)) begin
                    ox <= '0;
                    oy <= oy + 1'b1;
                end else begin
                    ox <= ox + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/filter_system.sv
// Image filter pipeline: RGB FIFO -> grayscale -> gray FIFO -> (sobel|bypass)
// -> output FIFO, under frame-level control.
// Define FILTER_SYSTEM_STATS_EN to add the stall_in_cnt/stall_out_cnt ports.
module filter_system
    import filter_system_pkg::*;
#(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540,
    parameter int RGB_DWIDTH = 24,
    parameter int PIX_DWIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  mode,
    output logic                  busy,
    output logic                  frame_done,
    input  logic                  in_wr_en,
    input  logic [RGB_DWIDTH-1:0] in_din,
    output logic                  in_full,
    input  logic                  out_rd_en,
    output logic [PIX_DWIDTH-1:0] out_dout,
    output logic                  out_empty
`ifdef FILTER_SYSTEM_STATS_EN
   ,output logic [31:0]           stall_in_cnt,
    output logic [31:0]           stall_out_cnt
`endif
);
    localparam int CW = RGB_DWIDTH / 3;

    logic                  mode_q, frame_clr, wr_accept;
    logic                  rgb_full, rgb_empty, rgb_rd;
    logic [RGB_DWIDTH-1:0] rgb_dout;
    logic [CW+1:0]         rgb_sum;
    logic                  g_vld;
    logic [PIX_DWIDTH-1:0] g_pix, gray_dout, sob_dout, out_din;
    logic                  gray_full, gray_empty, gray_rd;
    logic                  sob_sel, sob_empty, sob_rd, sob_wr;
    logic                  out_full, out_wr;

    frame_ctrl #(.W(IMG_WIDTH), .H(IMG_HEIGHT)) u_ctrl (
        .clock(clock), .reset(reset), .frame_start(frame_start), .mode(mode),
        .in_wr_en(in_wr_en), .rgb_full(rgb_full), .out_rd_en(out_rd_en),
        .out_empty(out_empty), .in_full(in_full), .wr_accept(wr_accept),
        .busy(busy), .frame_done(frame_done), .mode_q(mode_q), .frame_clr(frame_clr)
`ifdef FILTER_SYSTEM_STATS_EN
       ,.stall_in_cnt(stall_in_cnt), .stall_out_cnt(stall_out_cnt)
`endif
    );

    filter_system_fifo #(.DW(RGB_DWIDTH), .DEPTH(FIFO_DEPTH)) u_rgb_fifo (
        .clock(clock), .reset(reset), .wr_en(wr_accept), .din(in_din),
        .wr_pending(1'b0), .full(rgb_full), .rd_en(rgb_rd), .dout(rgb_dout),
        .empty(rgb_empty)
    );

    // The gray FIFO reports full one entry early while g_pix is in flight,
    // so a pixel popped from the RGB FIFO always has a slot waiting.
    filter_system_fifo #(.DW(PIX_DWIDTH), .DEPTH(FIFO_DEPTH)) u_gray_fifo (
        .clock(clock), .reset(reset), .wr_en(g_vld), .din(g_pix),
        .wr_pending(g_vld), .full(gray_full), .rd_en(gray_rd), .dout(gray_dout),
        .empty(gray_empty)
    );

    filter_system_sobel #(.W(IMG_WIDTH), .H(IMG_HEIGHT), .PW(PIX_DWIDTH)) u_sobel (
        .clock(clock), .reset(reset), .clr(frame_clr), .empty(sob_empty),
        .din(gray_dout), .rd_en(sob_rd), .full(out_full), .wr_en(sob_wr),
        .dout(sob_dout)
    );

    filter_system_fifo #(.DW(PIX_DWIDTH), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clock(clock), .reset(reset), .wr_en(out_wr), .din(out_din),
        .wr_pending(1'b0), .full(out_full), .rd_en(out_rd_en), .dout(out_dout),
        .empty(out_empty)
    );

    // Channel sum and sobel/bypass steering by the latched mode
    always_comb begin
        rgb_sum   = (CW+2)'(rgb_dout[3*CW-1:2*CW]) + (CW+2)'(rgb_dout[2*CW-1:CW]) +
                    (CW+2)'(rgb_dout[CW-1:0]);
        rgb_rd    = !rgb_empty && !gray_full;
        sob_sel   = (mode_q == MODE_SOBEL);
        sob_empty = sob_sel ? gray_empty : 1'b1;
        gray_rd   = sob_sel ? sob_rd : (!gray_empty && !out_full);
        out_wr    = sob_sel ? sob_wr : (!gray_empty && !out_full);
        out_din   = sob_sel ? sob_dout : gray_dout;
    end

    // Grayscale register stage: one cycle from RGB FIFO pop to gray FIFO push
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            g_vld <= 1'b0;
            g_pix <= '0;
        end else begin
            g_vld <= rgb_rd;
            if (rgb_rd) g_pix <= PIX_DWIDTH'(rgb_sum / (CW+2)'(3));
        end
    end
endmodule

// File: tb/tb_filter_system.sv
// Randomized frame-level bench for filter_system with a 2-D image reference.
module tb_filter_system;
    localparam int W = 8;
    localparam int H = 4;
    localparam int N = W * H;

    logic        clock = 1'b0;
    logic        reset, frame_start, mode, in_wr_en, out_rd_en;
    logic [23:0] in_din;
    logic        busy, frame_done, in_full, out_empty;
    logic [7:0]  out_dout;
`ifdef FILTER_SYSTEM_STATS_EN
    logic [31:0] stall_in_cnt, stall_out_cnt;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [23:0] pix [N];
    int          expv[N];

    filter_system #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .RGB_DWIDTH(24),
                    .PIX_DWIDTH(8), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset), .frame_start(frame_start), .mode(mode),
        .busy(busy), .frame_done(frame_done), .in_wr_en(in_wr_en), .in_din(in_din),
        .in_full(in_full), .out_rd_en(out_rd_en), .out_dout(out_dout),
        .out_empty(out_empty)
`ifdef FILTER_SYSTEM_STATS_EN
       ,.stall_in_cnt(stall_in_cnt), .stall_out_cnt(stall_out_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Image + expected output: kind 0 uniform, 1 left black/right white, 2 random
    task automatic build(input int kind, input logic [23:0] val, input bit m);
        int g[H][W];
        int gx, gy;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                case (kind)
                    0:       pix[y*W+x] = val;
                    1:       pix[y*W+x] = (x < W/2) ? 24'h000000 : 24'hFFFFFF;
                    default: pix[y*W+x] = 24'($urandom);
                endcase
                g[y][x] = (int'(pix[y*W+x][23:16]) + int'(pix[y*W+x][15:8]) +
                           int'(pix[y*W+x][7:0])) / 3;
            end
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                if (!m) expv[y*W+x] = g[y][x];
                else if (x == 0 || y == 0 || x == W-1 || y == H-1) expv[y*W+x] = 0;
                else begin
                    gx = (g[y-1][x+1] + 2*g[y][x+1] + g[y+1][x+1]) -
                         (g[y-1][x-1] + 2*g[y][x-1] + g[y+1][x-1]);
                    gy = (g[y+1][x-1] + 2*g[y+1][x] + g[y+1][x+1]) -
                         (g[y-1][x-1] + 2*g[y-1][x] + g[y-1][x+1]);
                    if (gx < 0) gx = -gx;
                    if (gy < 0) gy = -gy;
                    expv[y*W+x] = (gx + gy > 255) ? 255 : gx + gy;
                end
            end
    endtask

    // One full frame with random stalls; noisy toggles frame_start/mode mid-frame
    task automatic run_frame(input bit m, input bit noisy);
        int  wr = 0, rd = 0, cyc = 0;
        bit  pend = 0, fin = 0;
        @(negedge clock);
        frame_start = 1'b1; mode = m;
        @(negedge clock);
        frame_start = 1'b0;
        check("busy_after_start", busy, 1);
        while (!fin) begin
            check("frame_done_timing", frame_done, pend);
            if (pend) begin
                check("busy_in_done", busy, 0);
                in_wr_en = 1'b0; out_rd_en = 1'b0;
                frame_start = 1'b1;
                fin = 1;
            end else if (cyc >= 4000) begin
                check("timeout_reads", rd, N);
                in_wr_en = 1'b0; out_rd_en = 1'b0;
                fin = 1;
            end else begin
                if (noisy && busy) begin
                    frame_start = 1'($urandom_range(0, 1));
                    mode        = 1'($urandom_range(0, 1));
                end
                out_rd_en = ($urandom_range(0, 3) != 0);
                if (out_rd_en && !out_empty) begin
                    check($sformatf("pixel[%0d]", rd), out_dout, expv[rd]);
                    rd++;
                    if (rd == N) pend = 1;
                end
                if (wr < N) begin
                    in_wr_en = ($urandom_range(0, 3) != 0);
                    in_din   = pix[wr];
                    if (in_wr_en && !in_full) wr++;
                end else begin
                    in_wr_en = 1'b1;
                    in_din   = 24'hFFFFFF;
                    check("extra_write_blocked", in_full, 1);
                end
            end
            cyc++;
            @(negedge clock);
        end
        frame_start = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_in_full", in_full, 1);
        repeat (5) @(negedge clock);
        check("no_extra_output", out_empty, 1);
        check("no_second_done", frame_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr, cyc;
        reset = 1'b1; frame_start = 1'b0; mode = 1'b0;
        in_wr_en = 1'b0; out_rd_en = 1'b0; in_din = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        check("rst_in_full", in_full, 1);
        check("rst_out_empty", out_empty, 1);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_out_dout", out_dout, 0);

        build(0, 24'h303030, 0); run_frame(0, 0);
        build(0, 24'h505050, 1); run_frame(1, 0);
        build(1, 24'h0, 1);      run_frame(1, 1);
        build(2, 24'h0, 1);      run_frame(1, 1);
        build(2, 24'h0, 0);      run_frame(0, 1);

        // Abort a grayscale frame after 10 writes with an async reset
        build(2, 24'h0, 0);
        @(negedge clock);
        frame_start = 1'b1; mode = 1'b0;
        @(negedge clock);
        frame_start = 1'b0;
        wr = 0; cyc = 0;
        while (wr < 10 && cyc < 200) begin
            in_wr_en = 1'b1; in_din = pix[wr];
            if (!in_full) wr++;
            cyc++;
            @(negedge clock);
        end
        in_wr_en = 1'b0;
        check("abort_writes", wr, 10);
        check("pre_reset_busy", busy, 1);
        check("pre_reset_out_empty", out_empty, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_out_empty", out_empty, 1);
        check("mid_rst_in_full", in_full, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_dout", out_dout, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_out_empty", out_empty, 1);

        build(2, 24'h0, 1); run_frame(1, 0);
        build(0, 24'h123456, 0); run_frame(0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
